id_ex_vreg: RTL

- Parametrised ID/EX pipeline register for the SIMD AES pipeline.
- Carries scalar and vector (LANES x DATA_W) operands, immediate, register indices and control from decode to execute.
- Adds a valid bit, stall (hold), flush (bubble insert) and saturating bubble/stall performance counters.
- One clock edge of latency. No internal clock generation and no simulation-only timing.

---
 rtl/id_ex_vreg_if.sv | 46 ++++
 rtl/id_ex_vreg.sv | 93 +++++++++
 2 files changed

// File: rtl/id_ex_vreg_if.sv
// ID/EX pipeline register bus: decode-side operands/control in, execute-side
// registered copies and performance counters out.
interface id_ex_vreg_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 2,
  parameter int CNT_W  = 16
) ();
  localparam int VW = LANES * DATA_W;

  logic              stall;
  logic              flush;
  logic              ID_valid;
  logic [VW-1:0]     ID_data1, ID_data2;
  logic [DATA_W-1:0] ID_Imm;
  logic [REG_AW-1:0] ID_rd, ID_rs1, ID_rs2;
  logic [ALUC_W-1:0] ID_ALUControl;
  logic [1:0]        ID_MemToReg;
  logic              ID_RegWrite, ID_VRegWrite, ID_MemWrite, ID_ALUSrc;

  logic              EX_valid;
  logic [VW-1:0]     EX_data1, EX_data2;
  logic [DATA_W-1:0] EX_Imm;
  logic [REG_AW-1:0] EX_rd, EX_rs1, EX_rs2;
  logic [ALUC_W-1:0] EX_ALUControl;
  logic [1:0]        EX_MemToReg;
  logic              EX_RegWrite, EX_VRegWrite, EX_MemWrite, EX_ALUSrc;
  logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

  modport master (
    output stall, flush, ID_valid, ID_data1, ID_data2, ID_Imm, ID_rd, ID_rs1, ID_rs2,
           ID_ALUControl, ID_MemToReg, ID_RegWrite, ID_VRegWrite, ID_MemWrite, ID_ALUSrc,
    input  EX_valid, EX_data1, EX_data2, EX_Imm, EX_rd, EX_rs1, EX_rs2,
           EX_ALUControl, EX_MemToReg, EX_RegWrite, EX_VRegWrite, EX_MemWrite, EX_ALUSrc,
           bubble_cnt, stall_cnt
  );

  modport slave (
    input  stall, flush, ID_valid, ID_data1, ID_data2, ID_Imm, ID_rd, ID_rs1, ID_rs2,
           ID_ALUControl, ID_MemToReg, ID_RegWrite, ID_VRegWrite, ID_MemWrite, ID_ALUSrc,
    output EX_valid, EX_data1, EX_data2, EX_Imm, EX_rd, EX_rs1, EX_rs2,
           EX_ALUControl, EX_MemToReg, EX_RegWrite, EX_VRegWrite, EX_MemWrite, EX_ALUSrc,
           bubble_cnt, stall_cnt
  );
endinterface

// File: rtl/id_ex_vreg.sv
// ID/EX pipeline register for the SIMD AES pipeline. One edge of latency,
// priority rst > flush > stall > load, saturating bubble/stall counters.
module id_ex_vreg #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 2,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_vreg_if.slave bus
);
  localparam int VW = LANES * DATA_W;

  typedef struct packed {
    logic              valid;
    logic [VW-1:0]     data1;
    logic [VW-1:0]     data2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [ALUC_W-1:0] aluc;
    logic [1:0]        m2r;
    logic              rw;
    logic              vrw;
    logic              mw;
    logic              alusrc;
  } ex_t;

  ex_t              id_s, ex_q;
  logic             bub_inc, stl_inc;
  logic [CNT_W-1:0] bub_q, stl_q;

  // Gather decode slot; write enables are killed for an invalid slot so the
  // valid=0 -> no-writes invariant holds straight out of the register.
  always_comb begin
    id_s        = '0;
    id_s.valid  = bus.ID_valid;
    id_s.data1  = bus.ID_data1;
    id_s.data2  = bus.ID_data2;
    id_s.imm    = bus.ID_Imm;
    id_s.rd     = bus.ID_rd;
    id_s.rs1    = bus.ID_rs1;
    id_s.rs2    = bus.ID_rs2;
    id_s.aluc   = bus.ID_ALUControl;
    id_s.m2r    = bus.ID_MemToReg;
    id_s.rw     = bus.ID_valid & bus.ID_RegWrite;
    id_s.vrw    = bus.ID_valid & bus.ID_VRegWrite;
    id_s.mw     = bus.ID_valid & bus.ID_MemWrite;
    id_s.alusrc = bus.ID_ALUSrc;
  end

  // A bubble is either a flush or loading an empty decode slot; a stall only
  // counts when it is not overridden by a flush.
  assign bub_inc = bus.flush | (~bus.stall & ~bus.ID_valid);
  assign stl_inc = ~bus.flush & bus.stall;

  // Pipeline register: reset and flush both clear, stall holds, else load.
  always_ff @(posedge clk) begin
    if (rst)             ex_q <= '0;
    else if (bus.flush)  ex_q <= '0;
    else if (!bus.stall) ex_q <= id_s;
  end

  // Saturating performance counters; reset wins over any pending increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      bub_q <= '0;
      stl_q <= '0;
    end else begin
      if (bub_inc && (bub_q != '1)) bub_q <= bub_q + 1'b1;
      if (stl_inc && (stl_q != '1)) stl_q <= stl_q + 1'b1;
    end
  end

  assign bus.EX_valid      = ex_q.valid;
  assign bus.EX_data1      = ex_q.data1;
  assign bus.EX_data2      = ex_q.data2;
  assign bus.EX_Imm        = ex_q.imm;
  assign bus.EX_rd         = ex_q.rd;
  assign bus.EX_rs1        = ex_q.rs1;
  assign bus.EX_rs2        = ex_q.rs2;
  assign bus.EX_ALUControl = ex_q.aluc;
  assign bus.EX_MemToReg   = ex_q.m2r;
  assign bus.EX_RegWrite   = ex_q.rw;
  assign bus.EX_VRegWrite  = ex_q.vrw;
  assign bus.EX_MemWrite   = ex_q.mw;
  assign bus.EX_ALUSrc     = ex_q.alusrc;
  assign bus.bubble_cnt    = bub_q;
  assign bus.stall_cnt     = stl_q;
endmodule
